seam_dp_engine: RTL
===================

SEAM_DP_ENGINE -- requirements
Module: seam_dp_engine

Interface
REQ-001 Parameter OVERLAPWIDTH, default 300: seam search columns W, range 1..4096.
REQ-002 Parameter OVERLAPHEIGHT, default 1100: overlap rows H, range 1..4096.
REQ-003 Parameter PIX_W, default 8: width of each per-pixel difference value.
REQ-004 Parameter COST_W, default 32: width of each accumulated cost, at least PIX_W.
REQ-005 sys_clk  in  1  single clock; one clock domain, all logic on the rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 start  in  1  one-cycle pulse that begins a frame; ignored while busy=1.
REQ-008 in_valid / in_ready  in / out  1 / 1  difference-stream handshake; a beat transfers when both are 1.
REQ-009 in_diff  in  PIX_W  unsigned difference value, raster order: row 0 first, column 0 first within a row.
REQ-010 seam_valid / seam_ready  out / in  1 / 1  seam-output handshake.
REQ-011 seam_col  out  clog2(W) (min 1)  seam column for the current seam_row.
REQ-012 seam_row  out  clog2(H) (min 1)  row index; rows are emitted in order H-1 down to 0.
REQ-013 seam_last  out  1  high together with the row-0 beat.
REQ-014 busy / done  out / out  1 / 1  busy is high from start to the last seam beat; done is a one-cycle pulse after the last beat.

Function
REQ-015 The FSM SHALL have states IDLE, FIRST, ACCUM, SELECT, TRACE: IDLE->FIRST on start; FIRST->ACCUM after W beats; ACCUM->SELECT after beat H*W; SELECT->TRACE after W cycles; TRACE->IDLE on the seam_last handshake (if H=1, FIRST->SELECT).
REQ-016 in_ready SHALL be 1 only in FIRST and ACCUM, with no internal stall; the engine accepts one beat per cycle.
REQ-017 FIRST: cost[c] = in_diff, zero-extended to COST_W.
REQ-018 ACCUM: cost[c] = in_diff + min(prev[c-1], prev[c], prev[c+1]), where prev is the previous row's costs; the sum saturates at 2^COST_W-1.
REQ-019 Column 0 SHALL have no left candidate and column W-1 no right candidate; when W=1 only the centre candidate exists.
REQ-020 Tie-break for the minimum: centre, then left, then right.
REQ-021 Each ACCUM pixel SHALL store a 2-bit backpointer (0=left, 1=centre, 2=right) at address row*W+col; code 3 is never written.
REQ-022 SELECT SHALL scan the final-row costs for the minimum, choosing the lowest column on a tie, in exactly W cycles.
REQ-023 TRACE: the first beat is row H-1 at the selected column; each following row's column = current column + backpointer - 1.
REQ-024 seam_col, seam_row and seam_last SHALL hold stable while seam_valid=1 and seam_ready=0.
REQ-025 After a handshake, the next seam_valid SHALL rise exactly 2 cycles later, allowing for the synchronous RAM read.
REQ-026 done SHALL pulse in the cycle after the seam_last handshake; busy falls in that same cycle.
REQ-027 A start pulse while busy SHALL be ignored, with no effect on the frame in progress.
REQ-028 in_valid=0 pauses accumulation; cost and column state SHALL be held.

Reset
REQ-029 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and all column and row counters SHALL clear.
REQ-030 On reset: in_ready=0, seam_valid=0, seam_col=0, seam_row=0, seam_last=0, busy=0, done=0.
REQ-031 Cost and backpointer storage SHALL need no reset; stale contents must never be visible, since every frame overwrites before it reads.
REQ-032 A reset mid-frame SHALL abandon the frame; the next start runs a clean frame.

Structure
REQ-033 A shared package seam_pkg SHALL hold the FSM state enum, the backpointer codes (LEFT/CENTRE/RIGHT), and the width helper functions.
REQ-034 Backpointer storage SHALL be a separate sub-module seam_bp_ram: simple dual-port, 2-bit data, H*W depth, 1-cycle synchronous read.
REQ-035 The two cost rows (prev, cur) SHALL be ping-pong registers or RAM, swapped at each row end.

Verification (W=4, H=3 unless stated)
REQ-036 All in_diff=0 -> seam beats (row,col) = (2,0),(1,0),(0,0), seam_last on the third beat, then done.
REQ-037 in_diff=0 at (0,0),(1,1),(2,2) and 9 elsewhere -> seam beats (2,2),(1,1),(0,0).
REQ-038 COST_W=8, W=2, all in_diff=255 -> costs saturate at 255 with no wrap; seam column 0 on every row.
REQ-039 seam_ready held low for 5 cycles on the first beat -> outputs stable, no beat lost or duplicated, next seam_valid 2 cycles after the handshake.
REQ-040 rst_n low at ACCUM beat 6 -> next cycle in_ready=0 and busy=0; a new start then gives the same result as REQ-036.
REQ-041 start pulsed during TRACE -> ignored, and the seam sequence is unchanged.

Source files
------------

// File: rtl/seam_pkg.sv
// Shared types for the seam DP engine: FSM states, backpointer
// codes and the port-width helper.
package seam_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FIRST,
      ACCUM,
      SELECT,
      TRACE
   } state_t;

   typedef enum logic [1:0] {
      BP_LEFT   = 2'd0,
      BP_CENTRE = 2'd1,
      BP_RIGHT  = 2'd2
   } bp_t;

   // Index width for n entries, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seam_bp_ram.sv
// Backpointer store: simple dual-port, one write and one registered read.
// Ports: i_clk; write i_we/i_waddr/i_wdata; read i_raddr -> o_rdata (1 cycle).
module seam_bp_ram
   import seam_pkg::*;
#(
   parameter int DEPTH = 12,
   parameter int AW    = 4
)(
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  bp_t           i_wdata,
   input  logic [AW-1:0] i_raddr,
   output bp_t           o_rdata
);

   bp_t r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/seam_dp_engine.sv
// Min-cost vertical seam search over an H x W difference stream.
// Ports: sys_clk/rst_n; start; in_valid/in_ready/in_diff stream in;
// seam_valid/seam_ready/seam_col/seam_row/seam_last out; busy/done.
module seam_dp_engine
   import seam_pkg::*;
#(
   parameter int OVERLAPWIDTH  = 300,
   parameter int OVERLAPHEIGHT = 1100,
   parameter int PIX_W         = 8,
   parameter int COST_W        = 32
)(
   input  logic                                    sys_clk,
   input  logic                                    rst_n,
   input  logic                                    start,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [PIX_W-1:0]                        in_diff,
   output logic                                    seam_valid,
   input  logic                                    seam_ready,
   output logic [clog2_min1(OVERLAPWIDTH)-1:0]     seam_col,
   output logic [clog2_min1(OVERLAPHEIGHT)-1:0]    seam_row,
   output logic                                    seam_last,
   output logic                                    busy,
   output logic                                    done
);

   localparam int W  = OVERLAPWIDTH;
   localparam int H  = OVERLAPHEIGHT;
   localparam int CW = clog2_min1(W);
   localparam int RW = clog2_min1(H);
   localparam int AW = clog2_min1(W * H);

   state_t              r_state;
   logic [CW-1:0]       r_col;
   logic [RW-1:0]       r_row;
   logic                r_bank;
   logic [COST_W-1:0]   r_cost [2][W];
   logic [COST_W-1:0]   r_best;
   logic [CW-1:0]       r_bcol;
   logic                r_wait;

   logic                w_xfer;
   logic                w_pb;
   logic                w_col_end;
   logic                w_row_end;
   logic [COST_W-1:0]   w_pc;
   logic [COST_W-1:0]   w_pl;
   logic [COST_W-1:0]   w_pr;
   logic [COST_W-1:0]   w_min;
   bp_t                 w_bp;
   logic [COST_W:0]     w_sum;
   logic [COST_W-1:0]   w_acc;
   logic [COST_W-1:0]   w_cost_d;
   logic                w_take;
   logic [CW-1:0]       w_sel;
   logic [AW-1:0]       w_addr;
   logic                w_we;
   bp_t                 w_rd;
   logic [CW-1:0]       w_ncol;

   assign w_xfer    = in_valid & in_ready;
   // cur row is written into bank r_bank, prev row lives in the other
   assign w_pb      = ~r_bank;
   assign w_col_end = (r_col == CW'(W - 1));
   assign w_row_end = (r_row == RW'(H - 1));

   // Candidate order gives centre, then left, then right on ties
   always_comb begin
      w_pc  = r_cost[w_pb][r_col];
      w_pl  = '0;
      w_pr  = '0;
      w_min = w_pc;
      w_bp  = BP_CENTRE;
      if (r_col != '0) begin
         w_pl = r_cost[w_pb][r_col - CW'(1)];
         if (w_pl < w_min) begin
            w_min = w_pl;
            w_bp  = BP_LEFT;
         end
      end
      if (!w_col_end) begin
         w_pr = r_cost[w_pb][r_col + CW'(1)];
         if (w_pr < w_min) begin
            w_min = w_pr;
            w_bp  = BP_RIGHT;
         end
      end
   end

   assign w_sum    = {{(COST_W + 1 - PIX_W){1'b0}}, in_diff} + {1'b0, w_min};
   assign w_acc    = w_sum[COST_W] ? '1 : w_sum[COST_W-1:0];
   assign w_cost_d = (r_state == FIRST) ? COST_W'(in_diff) : w_acc;

   // Final-row scan: strict compare keeps the lowest column on ties
   assign w_take = (r_col == '0) || (w_pc < r_best);
   assign w_sel  = w_take ? r_col : r_bcol;

   // One address path: writes happen in ACCUM, reads matter in TRACE
   assign w_addr = (r_state == TRACE)
                 ? AW'(seam_row) * AW'(W) + AW'(seam_col)
                 : AW'(r_row) * AW'(W) + AW'(r_col);
   assign w_we   = w_xfer && (r_state == ACCUM);

   always_comb begin
      case (w_rd)
         BP_LEFT:  w_ncol = seam_col - CW'(1);
         BP_RIGHT: w_ncol = seam_col + CW'(1);
         default:  w_ncol = seam_col;
      endcase
   end

   seam_bp_ram #(
      .DEPTH (W * H),
      .AW    (AW)
   ) u_bp_ram (
      .i_clk   (sys_clk),
      .i_we    (w_we),
      .i_waddr (w_addr),
      .i_wdata (w_bp),
      .i_raddr (w_addr),
      .o_rdata (w_rd)
   );

   always_ff @(posedge sys_clk) begin
      if (w_xfer) r_cost[r_bank][r_col] <= w_cost_d;
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_col      <= '0;
         r_row      <= '0;
         r_bank     <= 1'b0;
         r_best     <= '0;
         r_bcol     <= '0;
         r_wait     <= 1'b0;
         in_ready   <= 1'b0;
         seam_valid <= 1'b0;
         seam_col   <= '0;
         seam_row   <= '0;
         seam_last  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_state  <= FIRST;
                  r_col    <= '0;
                  r_row    <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            FIRST: begin
               if (w_xfer) begin
                  if (w_col_end) begin
                     r_col  <= '0;
                     r_bank <= ~r_bank;
                     if (H == 1) begin
                        r_state  <= SELECT;
                        in_ready <= 1'b0;
                     end else begin
                        r_state <= ACCUM;
                        r_row   <= RW'(1);
                     end
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            ACCUM: begin
               if (w_xfer) begin
                  if (w_col_end) begin
                     r_col  <= '0;
                     r_bank <= ~r_bank;
                     if (w_row_end) begin
                        r_state  <= SELECT;
                        in_ready <= 1'b0;
                     end else begin
                        r_row <= r_row + RW'(1);
                     end
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            SELECT: begin
               if (w_take) r_best <= w_pc;
               r_bcol <= w_sel;
               if (w_col_end) begin
                  r_state    <= TRACE;
                  r_col      <= '0;
                  r_wait     <= 1'b0;
                  seam_col   <= w_sel;
                  seam_row   <= RW'(H - 1);
                  seam_last  <= (H == 1);
                  seam_valid <= 1'b1;
               end else begin
                  r_col <= r_col + CW'(1);
               end
            end
            TRACE: begin
               if (seam_valid && seam_ready) begin
                  seam_valid <= 1'b0;
                  if (seam_last) begin
                     r_state   <= IDLE;
                     seam_last <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     r_wait <= 1'b1;
                  end
               end else if (r_wait) begin
                  // backpointer for the accepted row is now on w_rd
                  r_wait     <= 1'b0;
                  seam_valid <= 1'b1;
                  seam_col   <= w_ncol;
                  seam_row   <= seam_row - RW'(1);
                  seam_last  <= (seam_row == RW'(1));
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
